// File: rtl/tone_player.sv
// Buzzer tone player: maps a 5-bit note code to a square wave, with a short
// silent articulation gap between two different consecutive notes.
module tone_player #(
  parameter int GAP_CYCLES = 120_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [4:0] tone,
  output logic       beep,
  output logic       playing
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [16:0] GAP_LAST = 17'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cur_q, cur_d;
  logic [14:0] cnt_q, cnt_d;
  logic [16:0] gap_q, gap_d;
  logic        beep_q, beep_d;
  logic        playing_q, playing_d;
  logic [14:0] half_cur;
  logic        tone_snd;

  // Octave 11 and note 0 are both silence.
  function automatic logic is_sounding(input logic [4:0] code);
    return (code[2:0] != 3'd0) && (code[4:3] != 2'b11);
  endfunction

  // Half period in sys_clk cycles, round(6e6 / f), C-major equal temperament.
  function automatic logic [14:0] half_of(input logic [4:0] code);
    logic [14:0] h;
    h = 15'd0;
    case (code)
      5'h01: h = 15'd22933;
      5'h02: h = 15'd20431;
      5'h03: h = 15'd18202;
      5'h04: h = 15'd17181;
      5'h05: h = 15'd15306;
      5'h06: h = 15'd13636;
      5'h07: h = 15'd12149;
      5'h09: h = 15'd11467;
      5'h0A: h = 15'd10216;
      5'h0B: h = 15'd9101;
      5'h0C: h = 15'd8590;
      5'h0D: h = 15'd7653;
      5'h0E: h = 15'd6818;
      5'h0F: h = 15'd6074;
      5'h11: h = 15'd5733;
      5'h12: h = 15'd5108;
      5'h13: h = 15'd4551;
      5'h14: h = 15'd4295;
      5'h15: h = 15'd3827;
      5'h16: h = 15'd3409;
      5'h17: h = 15'd3037;
      default: h = 15'd0;
    endcase
    return h;
  endfunction

  assign half_cur = half_of(cur_q);
  assign tone_snd = is_sounding(tone);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    beep_d    = beep_q;
    playing_d = playing_q;
    case (state_q)
      IDLE: begin
        beep_d = 1'b0;
        if (tone_snd) begin
          state_d = PLAY;
          cur_d   = tone;
          cnt_d   = 15'd0;
          beep_d  = 1'b1;
        end
      end
      PLAY: begin
        if (!tone_snd) begin
          state_d = IDLE;
          beep_d  = 1'b0;
          cur_d   = 5'd0;
          cnt_d   = 15'd0;
        end else if (tone != cur_q) begin
          state_d = GAP;
          beep_d  = 1'b0;
          cur_d   = tone;
          cnt_d   = 15'd0;
          gap_d   = 17'd0;
        end else if (cnt_q == half_cur - 15'd1) begin
          cnt_d  = 15'd0;
          beep_d = ~beep_q;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      GAP: begin
        beep_d = 1'b0;
        // A rest is checked first so it beats gap completion on the same edge.
        if (!tone_snd) begin
          state_d = IDLE;
          cur_d   = 5'd0;
          cnt_d   = 15'd0;
          gap_d   = 17'd0;
        end else if (tone != cur_q) begin
          cur_d = tone;
          gap_d = 17'd0;
        end else if (gap_q == GAP_LAST) begin
          state_d = PLAY;
          beep_d  = 1'b1;
          cnt_d   = 15'd0;
          gap_d   = 17'd0;
        end else begin
          gap_d = gap_q + 17'd1;
        end
      end
      default: begin
        state_d = IDLE;
        beep_d  = 1'b0;
        cur_d   = 5'd0;
        cnt_d   = 15'd0;
        gap_d   = 17'd0;
      end
    endcase
    playing_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cur_q     <= 5'd0;
      cnt_q     <= 15'd0;
      gap_q     <= 17'd0;
      beep_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      beep_q    <= beep_d;
      playing_q <= playing_d;
    end
  end

  assign beep    = beep_q;
  assign playing = playing_q;

endmodule
